// File: rtl/da_pkg.sv
// Shared constants, state encoding and width helper for the distributed-arithmetic MAC engine.
package da_pkg;

    localparam int DA_N_TAPS = 4;
    localparam int DA_DATA_W = 16;
    localparam int DA_COEF_W = 16;

    typedef enum logic [1:0] {
        DA_IDLE = 2'd0,
        DA_RUN  = 2'd1,
        DA_DONE = 2'd2
    } da_state_e;

    // A COEF_W x DATA_W signed product, and every partial sum on the way to it, fits here.
    function automatic int da_res_w(input int coef_w, input int data_w);
        return coef_w + data_w;
    endfunction

endpackage

// File: rtl/da_lut.sv
// Runtime-loadable partial-sum LUT: register file with synchronous write/clear and combinational read.
module da_lut #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // NOTE: default the whole next-state first; a write without it would infer a latch.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: this is flops, not a RAM macro, so a reset clear is cheap and gives a known table.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            // NOTE: sequential state only ever takes non-blocking assignments.
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/da_mac_engine.sv
// Bit-serial distributed-arithmetic MAC: one exact signed N_TAPS-sample dot-product per transaction.
module da_mac_engine
    import da_pkg::*;
#(
    parameter int N_TAPS = DA_N_TAPS,
    parameter int DATA_W = DA_DATA_W,
    parameter int COEF_W = DA_COEF_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_we,
    input  logic [N_TAPS-1:0]                     cfg_addr,
    input  logic [COEF_W-1:0]                     cfg_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_TAPS*DATA_W-1:0]              x,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [da_res_w(COEF_W, DATA_W)-1:0]   y,
    output logic                                  busy
);

    localparam int RES_W = da_res_w(COEF_W, DATA_W);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = DA_IDLE;
    localparam logic [1:0] S_RUN  = DA_RUN;
    localparam logic [1:0] S_DONE = DA_DONE;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N_TAPS*DATA_W-1:0] x_q, x_d;
    logic [RES_W-1:0]         acc_q, acc_d;
    logic [RES_W-1:0]         y_q, y_d;

    logic                     lut_we;
    logic [N_TAPS-1:0]        lut_addr;
    logic [COEF_W-1:0]        lut_data;
    logic [RES_W-1:0]         term_ext;
    logic [RES_W-1:0]         term;

    // The table is frozen while a transaction is in flight.
    assign lut_we = cfg_we && (state_q == S_IDLE);

    da_lut #(
        .ADDR_W (N_TAPS),
        .DATA_W (COEF_W)
    ) u_lut (
        .clk   (clk),
        .rst   (rst),
        .we    (lut_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (lut_addr),
        .rdata (lut_data)
    );

    // Each tap shifts right every RUN cycle, so bit 0 of every tap forms the current bit-plane address.
    always_comb begin
        for (int i = 0; i < N_TAPS; i++) begin
            lut_addr[i] = x_q[i*DATA_W];
        end
    end

    assign term_ext = {{DATA_W{lut_data[COEF_W-1]}}, lut_data};
    assign term     = term_ext << cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        acc_d   = acc_q;
        y_d     = y_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < N_TAPS; i++) begin
                    x_d[i*DATA_W +: DATA_W] = x_q[i*DATA_W +: DATA_W] >> 1;
                end
                // The sign-bit plane carries negative weight.
                if (cnt_q == CNT_LAST) begin
                    acc_d   = acc_q - term;
                    y_d     = acc_q - term;
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q + term;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign y         = y_q;

endmodule

// File: doc/da_mac_engine.md
# da_mac_engine

Parametrised distributed-arithmetic (DA) multiply-accumulate engine for the DCT datapath. It generalises the fixed 8-entry coefficient ROM into a runtime-loadable 2^N_TAPS-entry partial-sum LUT. It adds a bit-serial shift-accumulator that turns one N_TAPS-sample vector into one exact signed dot-product per transaction. It sits between the input sample buffer and the DCT output stage, one instance per DCT output coefficient.

## Interface

Parameters:
- N_TAPS, 4: samples per dot-product and LUT address width. Legal range 2..6.
- DATA_W, 16: sample width, two's complement. Minimum 2.
- COEF_W, 16: LUT entry width, two's complement.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  LUT write strobe.
- cfg_addr  in  N_TAPS  LUT write address.
- cfg_data  in  COEF_W  LUT write data.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine can accept a vector.
- x  in  N_TAPS*DATA_W  samples; tap i at x[i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  COEF_W+DATA_W  signed result.
- busy  out  1  high when state is not IDLE.

## Operation

- **LUT:** 2^N_TAPS × COEF_W registers.
  - A write occurs on a clock edge with cfg_we=1, and only while in IDLE.
  - cfg_we in RUN or DONE is ignored. The LUT is unchanged.
  - The LUT is read combinationally.
- **Address of bit plane k:** a_k[i] = bit k of tap i, with tap 0 as the address LSB.
- **Result:** y = Σ_{k=0}^{DATA_W-2} LUT[a_k]·2^k − LUT[a_{DATA_W-1}]·2^{DATA_W-1}.
  - The result is exact, with no rounding or saturation. COEF_W+DATA_W bits always suffice.
  - The MSB plane is subtracted (sign-bit weight).
- **FSM states:**
  - IDLE: in_ready=1. in_valid=1 latches x into the shift register, clears the accumulator and bit counter, and moves to RUN.
  - RUN: one bit plane per cycle, LSB first. The counter runs 0..DATA_W-1. When count=DATA_W-1, the final term is applied, y is registered, and the state moves to DONE.
  - DONE: out_valid=1 and y is held stable. out_ready=1 moves to IDLE. While out_ready=0, the state stays in DONE indefinitely.
- in_valid outside IDLE is ignored. x is not re-sampled.
- A simultaneous cfg_we and in_valid in IDLE performs the write on that edge. The new entry is visible from the first RUN cycle.
- LUT contents are fully software-defined. Offset-binary or plain DA tables are both legal. The block imposes no table structure.

## Timing

- **Reset:** rst=1 at an edge forces the following, regardless of current state, including mid-RUN and in DONE with out_valid=1:
  - state=IDLE, in_ready=1 after the edge.
  - out_valid=0, y=0, busy=0.
  - Counter and accumulator cleared.
  - All LUT entries set to 0.
- **Accept:** handshake on edge T. Cycles T+1..T+DATA_W are RUN. out_valid rises after edge T+DATA_W, so latency from accept to out_valid is DATA_W cycles.
- **Throughput:** with out_ready held at 1, one vector per DATA_W+2 cycles. The next accept occurs at edge T+DATA_W+2.
- in_ready is low from edge T+1 until the edge after the out_valid&&out_ready handshake.
- y changes only on the edge entering DONE or on reset.

## Structure

- **Package da_pkg:**
  - Default parameter constants.
  - State enum {IDLE, RUN, DONE}.
  - Function for the result width (COEF_W+DATA_W).
- **Sub-module da_lut:** parametrised register file.
  - Synchronous write with enable.
  - Combinational read.
  - Synchronous clear on rst.
- **Top:** FSM, bit counter ($clog2(DATA_W) bits), x shift register, accumulator.

## Test plan

All scenarios use default parameters.

- **Basic dot-product:** load LUT[a]=a for a=0..15. Send x={tap0=3, tap1=−1, tap2=5, tap3=0}. Expect y=21 and out_valid exactly 16 cycles after accept.
- **Negative extreme:** LUT[15]=0x7FFF, others 0. All taps 0x8000. Expect y=−1073709056 (0xC0008000).
- **Positive extreme:** LUT[15]=0x8000. All taps 0x7FFF. Expect y=−1073709056. Then LUT[1]=0x7FFF, tap0=0x7FFF, others 0. Expect y=1073676289.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid.
  - Expect y stable, in_ready=0, second in_valid ignored.
  - Release out_ready: in_ready=1 on the next cycle.
  - Next accept at DATA_W+2 cycles when out_ready is held at 1.
- **Config rules:** cfg_we during RUN (LUT[1]=0x1234) leaves LUT[1] unchanged, so the result matches the pre-write value. cfg_we together with in_valid in IDLE uses the new value.
- **Reset:** assert rst at RUN cycle 7 and separately in DONE.
  - Expect IDLE, out_valid=0, y=0, busy=0.
  - Afterwards, any vector yields y=0 (LUT cleared).
